mem_bus_arbiter: RTL and testbench

- Shares the single memory port (MAR, MBR_in/MBR_out, Mem_EN, Mem_CS) between two requesters: port 0 is the CPU and port 1 is the DMA/IO engine.
- Sequences each access as a req/done handshake with a fixed memory latency.
- Uses round-robin arbitration, so neither requester starves.
- Sits between the requesters and the memory module.

---
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two requesters (port 0 = CPU,
// port 1 = DMA/IO) with round-robin arbitration and a fixed memory latency.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req0/cs0/addr0/wdata0      port 0 request, op (0 rd / 1 wr), address, write data
//   rdata0/done0               port 0 registered read data, one-cycle completion pulse
//   req1/cs1/addr1/wdata1      port 1 request, op, address, write data
//   rdata1/done1               port 1 read data, completion pulse
//   MAR/MBR_out/Mem_EN/Mem_CS  memory address, write data, enable, op
//   MBR_in                     memory read data, valid MEM_LAT cycles after Mem_EN edge
//   owner                      port currently (or last) granted
//   busy                       high while an access or its done turnaround is in flight
module mem_bus_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        cs0,
  input  logic [7:0]  addr0,
  input  logic [15:0] wdata0,
  output logic [15:0] rdata0,
  output logic        done0,
  input  logic        req1,
  input  logic        cs1,
  input  logic [7:0]  addr1,
  input  logic [15:0] wdata1,
  output logic [15:0] rdata1,
  output logic        done1,
  output logic [7:0]  MAR,
  output logic [15:0] MBR_out,
  input  logic [15:0] MBR_in,
  output logic        Mem_EN,
  output logic        Mem_CS,
  output logic        owner,
  output logic        busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mbr_out_q, mbr_out_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_en_q, mem_en_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          gnt;

  // State and output registers; last_owner resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mar_q        <= '0;
      mbr_out_q    <= '0;
      mem_cs_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mar_q        <= mar_d;
      mbr_out_q    <= mbr_out_d;
      mem_cs_q     <= mem_cs_d;
      mem_en_q     <= mem_en_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
    end
  end

  // Arbitration, access sequencing and completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mar_d        = mar_q;
    mbr_out_d    = mbr_out_q;
    mem_cs_d     = mem_cs_q;
    mem_en_d     = 1'b0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    gnt          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the port that was not served last; a lone requester always wins.
          gnt          = (req0 && req1) ? ~last_owner_q : req1;
          mar_d        = gnt ? addr1  : addr0;
          mbr_out_d    = gnt ? wdata1 : wdata0;
          mem_cs_d     = gnt ? cs1    : cs0;
          mem_en_d     = 1'b1;
          owner_d      = gnt;
          last_owner_d = gnt;
          cnt_d        = CW'(MEM_LAT - 1);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Mem_EN is a single-cycle strobe; cnt reaching 0 marks MEM_LAT edges since grant.
        if (cnt_q == '0) begin
          if (!mem_cs_q) begin
            if (owner_q) rdata1_d = MBR_in;
            else         rdata0_d = MBR_in;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // Turnaround cycle: held requests are not looked at until IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign MAR     = mar_q;
  assign MBR_out = mbr_out_q;
  assign Mem_CS  = mem_cs_q;
  assign Mem_EN  = mem_en_q;
  assign owner   = owner_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (MEM_LAT 2, 1, 5), each with its own
// latency-accurate memory, checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       req0, cs0, req1, cs1;
  logic [2:0][7:0]  addr0, addr1;
  logic [2:0][15:0] wdata0, wdata1;
  logic [2:0][15:0] rdata0, rdata1, mbr_out, mbr_in;
  logic [2:0][7:0]  mar;
  logic [2:0]       done0, done1, mem_en, mem_cs, owner, busy;

  mem_bus_arbiter #(.MEM_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .cs0(cs0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .rdata0(rdata0[0]), .done0(done0[0]),
    .req1(req1[0]), .cs1(cs1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .rdata1(rdata1[0]), .done1(done1[0]),
    .MAR(mar[0]), .MBR_out(mbr_out[0]), .MBR_in(mbr_in[0]),
    .Mem_EN(mem_en[0]), .Mem_CS(mem_cs[0]), .owner(owner[0]), .busy(busy[0]));

  mem_bus_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .cs0(cs0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .rdata0(rdata0[1]), .done0(done0[1]),
    .req1(req1[1]), .cs1(cs1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .rdata1(rdata1[1]), .done1(done1[1]),
    .MAR(mar[1]), .MBR_out(mbr_out[1]), .MBR_in(mbr_in[1]),
    .Mem_EN(mem_en[1]), .Mem_CS(mem_cs[1]), .owner(owner[1]), .busy(busy[1]));

  mem_bus_arbiter #(.MEM_LAT(5)) u_dut2 (
    .clk(clk), .reset(reset),
    .req0(req0[2]), .cs0(cs0[2]), .addr0(addr0[2]), .wdata0(wdata0[2]),
    .rdata0(rdata0[2]), .done0(done0[2]),
    .req1(req1[2]), .cs1(cs1[2]), .addr1(addr1[2]), .wdata1(wdata1[2]),
    .rdata1(rdata1[2]), .done1(done1[2]),
    .MAR(mar[2]), .MBR_out(mbr_out[2]), .MBR_in(mbr_in[2]),
    .Mem_EN(mem_en[2]), .Mem_CS(mem_cs[2]), .owner(owner[2]), .busy(busy[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic logic [15:0] init_word(input logic [7:0] a);
    if (a == 8'h14) return 16'h3A05;
    return {a, ~a};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
    end
  endtask

  task automatic flag_fail(input string nm, input int k);
    total++;
    bad++;
    $display("FAIL %s inst%0d timed out t=%0t", nm, k, $time);
  endtask

  // Memory: data is driven only on the edge exactly MEM_LAT edges after the Mem_EN edge.
  logic [15:0] mem [3][256];
  logic [7:0]  maddr [3];
  int          mlat [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      mlat[k]  <= 0;
      maddr[k] <= '0;
      for (int a = 0; a < 256; a++) mem[k][a] <= init_word(8'(a));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_en[k]) begin
        mlat[k]  <= 1;
        maddr[k] <= mar[k];
        if (mem_cs[k]) mem[k][mar[k]] <= mbr_out[k];
      end else if (mlat[k] != 0 && mlat[k] < 32) begin
        mlat[k] <= mlat[k] + 1;
      end
    end
  end

  always_comb begin
    mbr_in = '0;
    for (int k = 0; k < 3; k++) begin
      if ((mem_en[k] && lat_of(k) == 1) ||
          (!mem_en[k] && mlat[k] != 0 && mlat[k] + 1 == lat_of(k)))
        mbr_in[k] = mem[k][mem_en[k] ? mar[k] : maddr[k]];
      else
        mbr_in[k] = 16'hDEAD;
    end
  end

  // Transaction model: an access granted at edge s completes at edge s+lat, and the
  // next grant may happen no earlier than two edges after completion.
  int          n_edge;
  bit          m_act [3], m_port [3], m_op [3], m_last [3];
  logic [7:0]  m_addr [3];
  logic [15:0] m_wd [3], m_rd0 [3], m_rd1 [3];
  int          m_start [3], m_done_at [3], m_free [3];
  logic [15:0] mdl_mem [3][256];
  logic [7:0]  e_mar [3];
  logic [15:0] e_mbr [3];
  bit          e_cs [3], e_en [3], e_own [3], e_busy [3], e_d0 [3], e_d1 [3];

  task automatic mdl_clear();
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 1'b0; m_last[k] = 1'b1; m_done_at[k] = -100; m_free[k] = 0;
      m_rd0[k] = '0; m_rd1[k] = '0;
      e_mar[k] = '0; e_mbr[k] = '0; e_cs[k] = 1'b0; e_en[k] = 1'b0;
      e_own[k] = 1'b0; e_busy[k] = 1'b0; e_d0[k] = 1'b0; e_d1[k] = 1'b0;
    end
  endtask

  task automatic mdl_step(input int k);
    bit p;
    bit changed;
    e_en[k] = 1'b0; e_d0[k] = 1'b0; e_d1[k] = 1'b0;
    if (m_act[k]) begin
      // Requester must hold its request fields stable for the whole access.
      if (m_port[k])
        changed = !req1[k] || cs1[k] != m_op[k] || addr1[k] != m_addr[k] || (m_op[k] && wdata1[k] != m_wd[k]);
      else
        changed = !req0[k] || cs0[k] != m_op[k] || addr0[k] != m_addr[k] || (m_op[k] && wdata0[k] != m_wd[k]);
      chk("contract", k, 16'(changed), 16'd0);
      if (n_edge == m_start[k] + lat_of(k)) begin
        if (!m_op[k]) begin
          if (m_port[k]) m_rd1[k] = mdl_mem[k][m_addr[k]];
          else           m_rd0[k] = mdl_mem[k][m_addr[k]];
        end
        m_act[k] = 1'b0; m_done_at[k] = n_edge; m_free[k] = n_edge + 2;
        if (m_port[k]) e_d1[k] = 1'b1;
        else           e_d0[k] = 1'b1;
      end
    end else if (n_edge >= m_free[k] && (req0[k] || req1[k])) begin
      p = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
      m_act[k] = 1'b1; m_port[k] = p; m_start[k] = n_edge; m_last[k] = p;
      m_op[k]   = p ? cs1[k]    : cs0[k];
      m_addr[k] = p ? addr1[k]  : addr0[k];
      m_wd[k]   = p ? wdata1[k] : wdata0[k];
      if (m_op[k]) mdl_mem[k][m_addr[k]] = m_wd[k];
      e_own[k] = p; e_mar[k] = m_addr[k]; e_mbr[k] = m_wd[k]; e_cs[k] = m_op[k]; e_en[k] = 1'b1;
    end
    e_busy[k] = m_act[k] || (n_edge == m_done_at[k]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) mdl_mem[k][a] = init_word(8'(a));
    mdl_clear();
    n_edge = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) mdl_clear();
      else begin
        n_edge++;
        for (int k = 0; k < 3; k++) mdl_step(k);
      end
    end
  end

  // Compare every output of every instance mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("MAR",     k, 16'(mar[k]),    16'(e_mar[k]));
        chk("MBR_out", k, mbr_out[k],     e_mbr[k]);
        chk("Mem_CS",  k, 16'(mem_cs[k]), 16'(e_cs[k]));
        chk("Mem_EN",  k, 16'(mem_en[k]), 16'(e_en[k]));
        chk("owner",   k, 16'(owner[k]),  16'(e_own[k]));
        chk("busy",    k, 16'(busy[k]),   16'(e_busy[k]));
        chk("done0",   k, 16'(done0[k]),  16'(e_d0[k]));
        chk("done1",   k, 16'(done1[k]),  16'(e_d1[k]));
        chk("rdata0",  k, rdata0[k],      m_rd0[k]);
        chk("rdata1",  k, rdata1[k],      m_rd1[k]);
      end
    end
  end

  // Stimulus helpers.
  bit grants [8];
  int n_gr;

  task automatic do_access(input int k, input bit p, input bit op, input logic [7:0] a,
                           input logic [15:0] wd, output int dly, output logic [7:0] s_mar,
                           output logic [15:0] s_mbr, output bit s_cs, output bit s_own);
    int guard;
    dly = -1; s_mar = '0; s_mbr = '0; s_cs = 1'b0; s_own = 1'b0;
    @(negedge clk);
    if (p) begin req1[k] = 1'b1; cs1[k] = op; addr1[k] = a; wdata1[k] = wd; end
    else   begin req0[k] = 1'b1; cs0[k] = op; addr0[k] = a; wdata0[k] = wd; end
    guard = 0;
    while (!mem_en[k] && guard < 40) begin @(negedge clk); guard++; end
    if (!mem_en[k]) begin
      flag_fail("grant_wait", k);
      req0[k] = 1'b0; req1[k] = 1'b0;
      return;
    end
    s_mar = mar[k]; s_mbr = mbr_out[k]; s_cs = mem_cs[k]; s_own = owner[k];
    dly = 0;
    while (!(p ? done1[k] : done0[k]) && dly < 40) begin @(negedge clk); dly++; end
    if (!(p ? done1[k] : done0[k])) flag_fail("done_wait", k);
    if (p) req1[k] = 1'b0;
    else   req0[k] = 1'b0;
  endtask

  task automatic both_req(input int k, input int n_each);
    int c0, c1, guard;
    c0 = 0; c1 = 0; guard = 0; n_gr = 0;
    @(negedge clk);
    req0[k] = 1'b1; cs0[k] = 1'b0; addr0[k] = 8'h10; wdata0[k] = '0;
    req1[k] = 1'b1; cs1[k] = 1'b0; addr1[k] = 8'h20; wdata1[k] = '0;
    while ((c0 < n_each || c1 < n_each) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (mem_en[k] && n_gr < 8) begin grants[n_gr] = owner[k]; n_gr++; end
      if (done0[k]) begin c0++; if (c0 == n_each) req0[k] = 1'b0; end
      if (done1[k]) begin c1++; if (c1 == n_each) req1[k] = 1'b0; end
    end
    if (c0 < n_each || c1 < n_each) begin
      flag_fail("contention_wait", k);
      req0[k] = 1'b0; req1[k] = 1'b0;
    end
  endtask

  int          dly;
  logic [7:0]  s_mar;
  logic [15:0] s_mbr;
  bit          s_cs, s_own;

  initial begin
    reset = 1'b1;
    req0 = '0; cs0 = '0; addr0 = '0; wdata0 = '0;
    req1 = '0; cs1 = '0; addr1 = '0; wdata1 = '0;
    n_gr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: no enable, not busy.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("idle_en",   k, 16'(mem_en[k]), 16'd0);
        chk("idle_busy", k, 16'(busy[k]),   16'd0);
      end
    end

    // Single read on port 0.
    do_access(0, 1'b0, 1'b0, 8'h14, 16'h0000, dly, s_mar, s_mbr, s_cs, s_own);
    chk("rd_lat",   0, 16'(dly),   16'd2);
    chk("rd_mar",   0, 16'(s_mar), 16'h0014);
    chk("rd_cs",    0, 16'(s_cs),  16'd0);
    chk("rd_owner", 0, 16'(s_own), 16'd0);
    chk("rd_data",  0, rdata0[0],  16'h3A05);

    // Single write on port 1.
    do_access(0, 1'b1, 1'b1, 8'h30, 16'hBEEF, dly, s_mar, s_mbr, s_cs, s_own);
    chk("wr_lat",    0, 16'(dly),   16'd2);
    chk("wr_mar",    0, 16'(s_mar), 16'h0030);
    chk("wr_mbr",    0, s_mbr,      16'hBEEF);
    chk("wr_cs",     0, 16'(s_cs),  16'd1);
    chk("wr_owner",  0, 16'(s_own), 16'd1);
    chk("wr_rdata1", 0, rdata1[0],  16'h0000);
    chk("wr_rdata0", 0, rdata0[0],  16'h3A05);

    // Contention: both ports request twice each; grants alternate starting with port 0.
    both_req(0, 2);
    chk("cont_ngr", 0, 16'(n_gr), 16'd4);
    for (int i = 0; i < 4; i++) chk("cont_order", 0, 16'(grants[i]), 16'(i % 2));
    chk("cont_rd0", 0, rdata0[0], 16'h10EF);
    chk("cont_rd1", 0, rdata1[0], 16'h20DF);

    // Reset during an access: enable drops at once, read data clears, no done.
    @(negedge clk);
    req0[0] = 1'b1; cs0[0] = 1'b0; addr0[0] = 8'h14;
    for (int g = 0; g < 40 && !mem_en[0]; g++) @(negedge clk);
    if (!mem_en[0]) flag_fail("rst_grant_wait", 0);
    #2;
    reset = 1'b1;
    req0[0] = 1'b0;
    #1;
    chk("rst_en",     0, 16'(mem_en[0]), 16'd0);
    chk("rst_rdata0", 0, rdata0[0],      16'h0000);
    chk("rst_busy",   0, 16'(busy[0]),   16'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_done0", 0, 16'(done0[0]), 16'd0);
    end
    reset = 1'b0;

    // Lone port 1 request is served, then a simultaneous request goes to port 0.
    do_access(0, 1'b1, 1'b0, 8'h55, 16'h0000, dly, s_mar, s_mbr, s_cs, s_own);
    chk("post_owner", 0, 16'(s_own), 16'd1);
    chk("post_rd1",   0, rdata1[0],  16'h55AA);
    both_req(0, 1);
    chk("tie_ngr", 0, 16'(n_gr), 16'd2);
    for (int i = 0; i < 2; i++) chk("tie_order", 0, 16'(grants[i]), 16'(i % 2));

    // Latency sweep.
    do_access(1, 1'b0, 1'b0, 8'h14, 16'h0000, dly, s_mar, s_mbr, s_cs, s_own);
    chk("lat1_dly",  1, 16'(dly),  16'd1);
    chk("lat1_data", 1, rdata0[1], 16'h3A05);
    do_access(2, 1'b1, 1'b0, 8'h44, 16'h0000, dly, s_mar, s_mbr, s_cs, s_own);
    chk("lat5_dly",  2, 16'(dly),  16'd5);
    chk("lat5_data", 2, rdata1[2], 16'h44BB);

    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
